// File: rtl/fp_mult_pkg.sv
// fp_mult_pkg: shared IEEE-754 single-precision types, status bit indices and checker types
package fp_mult_pkg;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } ieee_single_precision;
  typedef enum logic [1:0] {ROUND_NEAREST_EVEN, ROUND_ZERO, ROUND_UP, ROUND_DOWN} round_values;
  localparam int ZERO = 0;
  localparam int INF = 1;
  localparam int NAN = 2;
  localparam int TINY = 3;
  localparam int HUGE = 4;
  localparam int INEXACT = 5;
  typedef enum logic [1:0] {IDLE, RUN, HOLD} chk_state_e;
  typedef struct packed {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    logic [31:0] z_ref;
    logic [7:0]  status;
  } chk_txn_t;
  function automatic logic is_nan(input ieee_single_precision v);
    return v.exponent == 8'hFF && v.mantissa != '0;
  endfunction
  function automatic logic is_inf(input ieee_single_precision v);
    return v.exponent == 8'hFF && v.mantissa == '0;
  endfunction
  function automatic logic is_zero(input ieee_single_precision v);
    return v.exponent == '0 && v.mantissa == '0;
  endfunction
endpackage

// File: rtl/fp_class_check.sv
// fp_class_check: flags a result whose zero/inf/nan status bits disagree with its class
module fp_class_check
  import fp_mult_pkg::*;
(
  input  logic [31:0]     z,
  input  logic [NAN:ZERO] status,
  output logic            fmis
);
  always_comb fmis = status[ZERO] != is_zero(z) || status[INF] != is_inf(z) || status[NAN] != is_nan(z);
endmodule

// File: rtl/fp_mult_checker.sv
// fp_mult_checker: two-stage result checker with saturating statistics and first-failure capture
module fp_mult_checker
  import fp_mult_pkg::*;
#(
  parameter bit NAN_EQUIV = 1'b1,
  parameter int CNT_W = 32,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic [31:0]      z,
  input  logic [31:0]      z_ref,
  input  logic [7:0]       status,
  output logic             armed,
  output logic             done,
  output logic             err_pulse,
  output logic [CNT_W-1:0] txn_cnt,
  output logic [ERR_W-1:0] val_err_cnt,
  output logic [ERR_W-1:0] flag_err_cnt,
  output logic             first_valid,
  output logic [31:0]      first_a,
  output logic [31:0]      first_b,
  output logic [31:0]      first_z,
  output logic [31:0]      first_ref,
  output logic [7:0]       first_status
);
  chk_state_e state_q, state_d;
  chk_txn_t s1_q, s1_d, s2_q, s2_d, first_q, first_d;
  logic armed_q, armed_d, done_q, done_d, err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] txn_cnt_q, txn_cnt_d;
  logic [ERR_W-1:0] val_err_cnt_q, val_err_cnt_d, flag_err_cnt_q, flag_err_cnt_d;
  logic vmis, fmis, hit;
  fp_class_check u_class (.z(s2_q.z), .status(s2_q.status[NAN:ZERO]), .fmis(fmis));
  // start clears the stage-2 transaction instead of counting it
  always_comb begin
    s1_d = {in_valid, a, b, z, z_ref, status};
    s2_d = s1_q;
    vmis = s2_q.z != s2_q.z_ref && !(NAN_EQUIV && is_nan(s2_q.z) && is_nan(s2_q.z_ref));
    hit = s2_q.valid && state_q == RUN && !start;
    state_d = start ? RUN : (stop && state_q == RUN) ? HOLD : state_q;
    armed_d = state_d == RUN;
    done_d = state_d == HOLD;
    err_pulse_d = hit && (vmis || fmis);
    txn_cnt_d = start ? '0 : txn_cnt_q + CNT_W'(hit);
    val_err_cnt_d = start ? '0 : val_err_cnt_q + ERR_W'(hit && vmis && val_err_cnt_q != '1);
    flag_err_cnt_d = start ? '0 : flag_err_cnt_q + ERR_W'(hit && fmis && flag_err_cnt_q != '1);
    first_d = start ? '0 : (err_pulse_d && !first_q.valid) ? s2_q : first_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      s1_q <= '0;
      s2_q <= '0;
      first_q <= '0;
      armed_q <= 1'b0;
      done_q <= 1'b0;
      err_pulse_q <= 1'b0;
      txn_cnt_q <= '0;
      val_err_cnt_q <= '0;
      flag_err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      first_q <= first_d;
      armed_q <= armed_d;
      done_q <= done_d;
      err_pulse_q <= err_pulse_d;
      txn_cnt_q <= txn_cnt_d;
      val_err_cnt_q <= val_err_cnt_d;
      flag_err_cnt_q <= flag_err_cnt_d;
    end
  assign armed = armed_q;
  assign done = done_q;
  assign err_pulse = err_pulse_q;
  assign txn_cnt = txn_cnt_q;
  assign val_err_cnt = val_err_cnt_q;
  assign flag_err_cnt = flag_err_cnt_q;
  assign first_valid = first_q.valid;
  assign first_a = first_q.a;
  assign first_b = first_q.b;
  assign first_z = first_q.z;
  assign first_ref = first_q.z_ref;
  assign first_status = first_q.status;
endmodule

// File: tb/tb_fp_mult_checker.sv
// tb_fp_mult_checker: random and directed scoreboard bench for both NAN_EQUIV settings
module tb_fp_mult_checker;
  logic clk = 1'b0;
  logic rst, start, stop, in_valid;
  logic [31:0] a, b, z, z_ref;
  logic [7:0] status;
  logic armed[2], done[2], err_pulse[2], first_valid[2];
  logic [31:0] txn_cnt[2], first_a[2], first_b[2], first_z[2], first_ref[2];
  logic [15:0] val_err_cnt[2], flag_err_cnt[2];
  logic [7:0] first_status[2];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  fp_mult_checker #(.NAN_EQUIV(1'b0)) u0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid),
    .a(a), .b(b), .z(z), .z_ref(z_ref), .status(status),
    .armed(armed[0]), .done(done[0]), .err_pulse(err_pulse[0]), .txn_cnt(txn_cnt[0]),
    .val_err_cnt(val_err_cnt[0]), .flag_err_cnt(flag_err_cnt[0]), .first_valid(first_valid[0]),
    .first_a(first_a[0]), .first_b(first_b[0]), .first_z(first_z[0]), .first_ref(first_ref[0]),
    .first_status(first_status[0]));
  fp_mult_checker #(.NAN_EQUIV(1'b1)) u1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid),
    .a(a), .b(b), .z(z), .z_ref(z_ref), .status(status),
    .armed(armed[1]), .done(done[1]), .err_pulse(err_pulse[1]), .txn_cnt(txn_cnt[1]),
    .val_err_cnt(val_err_cnt[1]), .flag_err_cnt(flag_err_cnt[1]), .first_valid(first_valid[1]),
    .first_a(first_a[1]), .first_b(first_b[1]), .first_z(first_z[1]), .first_ref(first_ref[1]),
    .first_status(first_status[1]));

  typedef struct {
    bit rs, st, sp, v;
    logic [31:0] a, b, z, zr;
    logic [7:0] s;
  } rec_t;
  rec_t q[$];

  task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s u%0d got %h expected %h at %0t", name, k, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] flags(logic [31:0] v);
    logic [31:0] m;
    m = v & 32'h7FFF_FFFF;
    return {m > 32'h7F80_0000, m == 32'h7F80_0000, m == 32'h0};
  endfunction

  function automatic bit vbad(rec_t r, int k);
    return r.z != r.zr && !(k == 1 && flags(r.z)[2] && flags(r.zr)[2]);
  endfunction

  function automatic logic [31:0] rand_val();
    logic [31:0] sgn;
    sgn = 32'($urandom_range(0, 1)) << 31;
    case ($urandom_range(0, 4))
      0: return sgn;
      1: return sgn | 32'h7F80_0000;
      2: return sgn | 32'h7F80_0000 | 32'($urandom_range(1, 32'h7F_FFFF));
      default: return $urandom();
    endcase
  endfunction

  // Monitor: spec-level model of the checker fed by the per-edge stimulus record
  typedef enum {M_IDLE, M_RUN, M_HOLD} mst_e;
  mst_e mst = M_IDLE;
  logic [31:0] m_txn;
  logic [15:0] m_verr[2], m_ferr[2];
  bit m_pulse[2], m_fv[2];
  rec_t m_first[2];
  rec_t dl[$];

  task automatic clear_stats();
    m_txn = 0;
    for (int k = 0; k < 2; k++) begin
      m_verr[k] = 0; m_ferr[k] = 0; m_fv[k] = 0;
      m_first[k] = '{default: '0};
    end
  endtask

  initial begin
    rec_t r, ev;
    bit ev_ok, vb, fb;
    forever begin
      @(negedge clk);
      if (q.size() == 0) continue;
      r = q.pop_front();
      m_pulse = '{0, 0};
      if (r.rs) begin
        mst = M_IDLE;
        clear_stats();
        dl.delete();
      end else begin
        dl.push_back(r);
        ev_ok = 0;
        if (dl.size() == 3) begin
          ev = dl.pop_front();
          ev_ok = ev.v && mst == M_RUN && !r.st;
        end
        if (r.st) clear_stats();
        else if (ev_ok) begin
          m_txn++;
          fb = ev.s[2:0] != flags(ev.z);
          for (int k = 0; k < 2; k++) begin
            vb = vbad(ev, k);
            if (vb && m_verr[k] != 16'hFFFF) m_verr[k]++;
            if (fb && m_ferr[k] != 16'hFFFF) m_ferr[k]++;
            if (vb || fb) begin
              m_pulse[k] = 1;
              if (!m_fv[k]) begin m_fv[k] = 1; m_first[k] = ev; end
            end
          end
        end
        if (r.st) mst = M_RUN;
        else if (r.sp && mst == M_RUN) mst = M_HOLD;
      end
      for (int k = 0; k < 2; k++) begin
        chk("armed", k, 32'(armed[k]), 32'(mst == M_RUN));
        chk("done", k, 32'(done[k]), 32'(mst == M_HOLD));
        chk("err_pulse", k, 32'(err_pulse[k]), 32'(m_pulse[k]));
        chk("txn_cnt", k, txn_cnt[k], m_txn);
        chk("val_err_cnt", k, 32'(val_err_cnt[k]), 32'(m_verr[k]));
        chk("flag_err_cnt", k, 32'(flag_err_cnt[k]), 32'(m_ferr[k]));
        chk("first_valid", k, 32'(first_valid[k]), 32'(m_fv[k]));
        chk("first_a", k, first_a[k], m_first[k].a);
        chk("first_b", k, first_b[k], m_first[k].b);
        chk("first_z", k, first_z[k], m_first[k].z);
        chk("first_ref", k, first_ref[k], m_first[k].zr);
        chk("first_status", k, 32'(first_status[k]), 32'(m_first[k].s));
      end
    end
  end

  task automatic step(bit rs, bit st, bit sp, bit v, logic [31:0] ia, logic [31:0] iz,
                      logic [31:0] izr, logic [7:0] is);
    rec_t r;
    r = '{rs: rs, st: st, sp: sp, v: v, a: ia, b: $urandom(), z: iz, zr: izr, s: is};
    rst = rs; start = st; stop = sp; in_valid = v;
    a = r.a; b = r.b; z = iz; z_ref = izr; status = is;
    q.push_back(r);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, $urandom(), $urandom(), $urandom(), 8'h00);
  endtask

  task automatic rand_txn(bit st, bit sp);
    logic [31:0] zz, rr;
    logic [7:0] s;
    zz = rand_val();
    rr = ($urandom_range(0, 3) == 0) ? rand_val() : zz;
    s = {5'($urandom()), flags(zz)};
    if ($urandom_range(0, 3) == 0) s[$urandom_range(0, 2)] ^= 1'b1;
    step(0, st, sp, $urandom_range(0, 3) != 0, $urandom(), zz, rr, s);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 32'h3F80_0000, 32'h3F80_0000, 8'h00);
    step(0, 0, 0, 1, 2, 32'h0, 32'h0, 8'h00);
    idle(2);
    step(0, 1, 0, 1, 3, 32'h3F80_0000, 32'h3F80_0000, 8'h00);
    idle(3);
    chk("one_txn", 0, txn_cnt[0], 32'd1);
    step(0, 0, 0, 1, 4, 32'h7FC0_0000, 32'h7FA0_0000, 8'h04);
    step(0, 0, 0, 1, 5, 32'h0, 32'h0, 8'h00);
    idle(3);
    chk("nan_equiv_verr", 1, 32'(val_err_cnt[1]), 32'd0);
    chk("nan_exact_verr", 0, 32'(val_err_cnt[0]), 32'd1);
    chk("nan_exact_first_z", 0, first_z[0], 32'h7FC0_0000);
    chk("zero_ferr", 1, 32'(flag_err_cnt[1]), 32'd1);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h1111_1111, 32'h3F80_0000, 32'h4000_0000, 8'h00);
    step(0, 0, 0, 1, 32'h2222_2222, 32'h3F80_0000, 32'h4000_0000, 8'h00);
    idle(3);
    chk("b2b_verr", 0, 32'(val_err_cnt[0]), 32'd2);
    chk("b2b_first_a", 0, first_a[0], 32'h1111_1111);
    for (int i = 0; i < 3000; i++) rand_txn($urandom_range(0, 99) == 0, $urandom_range(0, 99) == 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 70000; i++) step(0, 0, 0, 1, $urandom(), 32'h3F80_0000, 32'h4000_0000, 8'h00);
    idle(3);
    chk("sat_verr", 1, 32'(val_err_cnt[1]), 32'h0000_FFFF);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    idle(3);
    chk("restart_verr", 1, 32'(val_err_cnt[1]), 32'd0);
    chk("restart_first_valid", 1, 32'(first_valid[1]), 32'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, $urandom(), 32'h3F80_0000, 32'h4000_0000, 8'h00);
    step(1, 0, 0, 1, 0, 32'h3F80_0000, 32'h4000_0000, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, $urandom(), 32'h3F80_0000, 32'h4000_0000, 8'h00);
    chk("post_rst_txn", 0, txn_cnt[0], 32'd0);
    chk("post_rst_armed", 0, 32'(armed[0]), 32'd0);
    step(0, 1, 0, 1, 7, 32'h3F80_0000, 32'h3F80_0000, 8'h00);
    for (int i = 0; i < 3; i++) rand_txn(0, 0);
    idle(3);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
